harness_cmd_bridge: RTL

Synthesizable hardware end of the host simulation-command byte protocol: accepts single-byte commands over a valid/ready byte stream, drives the wrapped DUT's packed input vector, reset and step enable, and returns the DUT's packed output vector as a byte stream. It sits between a host byte transport (UART/USB FIFO) and the packed `data_in`/`data_out` buses of a compiled module, so the same host driver runs against silicon and simulation.

---
 rtl/harness_cmd_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/harness_cmd_bridge.sv
// Byte-stream command bridge between a host transport and a wrapped DUT's packed I/O buses.
// Decodes single-byte commands, loads dut_in from payload bytes and streams dut_out back LSB first.
module harness_cmd_bridge #(
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [INPUT_SIZE-1:0]  dut_in,
    input  logic [OUTPUT_SIZE-1:0] dut_out,
    output logic                   dut_rst,
    output logic                   dut_step,
    output logic                   done,
    output logic                   error
);

    localparam int INPUT_BYTES  = (INPUT_SIZE + 7) / 8;
    localparam int OUTPUT_WORDS = (OUTPUT_SIZE + 31) / 32;
    localparam int STAGE_W      = INPUT_BYTES * 8;
    localparam int SNAP_W       = OUTPUT_WORDS * 32;
    localparam int SEND_BYTES   = OUTPUT_WORDS * 4;
    localparam int LCW          = $clog2(INPUT_BYTES + 1);
    localparam int SCW          = $clog2(SEND_BYTES + 1);

    localparam logic [7:0] CMD_SAMPLE    = 8'd104;
    localparam logic [7:0] CMD_FINISH    = 8'd105;
    localparam logic [7:0] CMD_RST_ON    = 8'd106;
    localparam logic [7:0] CMD_RST_OFF   = 8'd107;
    localparam logic [7:0] CMD_STEP      = 8'd108;
    localparam logic [7:0] CMD_LOAD      = 8'd109;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_HALT
    } state_t;

    state_t state;
    state_t state_next;

    logic [STAGE_W-1:0] stage;
    logic [STAGE_W-1:0] stage_shifted;
    logic [LCW-1:0]     load_cnt;
    logic [SNAP_W-1:0]  snapshot;
    logic [SCW-1:0]     send_cnt;

    logic rx_accept;
    logic tx_fire;
    logic start_load;
    logic load_byte;
    logic load_last;
    logic capture;
    logic send_byte;
    logic set_rst;
    logic clr_rst;
    logic step_cmd;
    logic set_done;
    logic set_error;

    assign rx_accept = rx_valid && rx_ready;
    assign tx_valid  = (state == ST_SEND);
    assign tx_fire   = tx_valid && tx_ready;
    assign tx_data   = snapshot[7:0];

    // New payload byte enters at the top so the first byte ends up least significant.
    assign stage_shifted = (stage >> 8) | (STAGE_W'(rx_data) << (STAGE_W - 8));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        load_byte  = 1'b0;
        load_last  = 1'b0;
        capture    = 1'b0;
        send_byte  = 1'b0;
        set_rst    = 1'b0;
        clr_rst    = 1'b0;
        step_cmd   = 1'b0;
        set_done   = 1'b0;
        set_error  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_accept) begin
                    case (rx_data)
                        CMD_SAMPLE: begin
                            capture    = 1'b1;
                            state_next = ST_SEND;
                        end
                        CMD_FINISH: begin
                            set_done   = 1'b1;
                            state_next = ST_HALT;
                        end
                        CMD_RST_ON:  set_rst  = 1'b1;
                        CMD_RST_OFF: clr_rst  = 1'b1;
                        CMD_STEP:    step_cmd = 1'b1;
                        CMD_LOAD: begin
                            start_load = 1'b1;
                            state_next = ST_LOAD;
                        end
                        default: begin
                            set_error  = 1'b1;
                            state_next = ST_HALT;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (rx_accept) begin
                    load_byte = 1'b1;
                    if (load_cnt == LCW'(INPUT_BYTES - 1)) begin
                        load_last  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_SEND: begin
                if (tx_fire) begin
                    send_byte = 1'b1;
                    if (send_cnt == SCW'(SEND_BYTES - 1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // rx_ready is registered from the next state so it drops right after a sample/finish/bad byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready <= 1'b0;
            stage    <= '0;
            load_cnt <= '0;
            snapshot <= '0;
            send_cnt <= '0;
            dut_in   <= '0;
            dut_rst  <= 1'b1;
            dut_step <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            rx_ready <= (state_next == ST_IDLE) || (state_next == ST_LOAD);
            dut_step <= step_cmd;
            if (set_rst) begin
                dut_rst <= 1'b1;
            end
            if (clr_rst) begin
                dut_rst <= 1'b0;
            end
            if (set_done) begin
                done <= 1'b1;
            end
            if (set_error) begin
                error <= 1'b1;
            end
            if (start_load) begin
                load_cnt <= '0;
            end
            if (load_byte) begin
                stage    <= stage_shifted;
                load_cnt <= load_cnt + LCW'(1);
                if (load_last) begin
                    dut_in <= stage_shifted[INPUT_SIZE-1:0];
                end
            end
            if (capture) begin
                snapshot <= SNAP_W'(dut_out);
                send_cnt <= '0;
            end
            if (send_byte) begin
                snapshot <= snapshot >> 8;
                send_cnt <= send_cnt + SCW'(1);
            end
        end
    end

endmodule
